// File: rtl/fetch_line_packer_if.sv
// Beat input and line output bundle for fetch_line_packer.
// master = packer side, slave = producer/consumer side.
interface fetch_line_packer_if #(
  parameter int LINE_BYTES = 64,
  parameter int IN_BYTES   = 16,
  parameter int ADDR       = 32
);
  localparam int NW = $clog2(IN_BYTES + 1);

  logic                    in_valid;
  logic                    in_ready;
  logic [IN_BYTES*8-1:0]   in_data;
  logic [NW-1:0]           in_bytes;
  logic                    in_last;
  logic                    out_valid;
  logic [ADDR-1:0]         out_addr;
  logic [LINE_BYTES*8-1:0] out_data;
  logic [LINE_BYTES-1:0]   out_strb;
  logic                    out_done;

  modport master (
    input  in_valid, in_data, in_bytes, in_last, out_done,
    output in_ready, out_valid, out_addr, out_data, out_strb
  );

  modport slave (
    output in_valid, in_data, in_bytes, in_last, out_done,
    input  in_ready, out_valid, out_addr, out_data, out_strb
  );
endinterface

// File: rtl/fetch_line_packer.sv
// Packs variable-width column beats into aligned output lines
// with strobes, unaligned base, partial flush and backpressure.
module fetch_line_packer #(
  parameter int LINE_BYTES = 64,
  parameter int IN_BYTES   = 16,
  parameter int ADDR       = 32,
  parameter int CNT_W      = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR-1:0]    base_addr,
  fetch_line_packer_if.master bus,
  output logic               busy,
  output logic [CNT_W-1:0]   lines_emitted
);
  localparam int LW = $clog2(LINE_BYTES);
  localparam int SW = LW + 1;
  localparam int NW = $clog2(IN_BYTES + 1);
  localparam int DW = LINE_BYTES * 8;

  typedef enum logic [1:0] {
    IDLE, FILL, FLUSH, DRAIN
  } state_e;

  state_e                state_q;
  logic [LW-1:0]         fill_q;
  logic [ADDR-1:0]       line_addr_q;
  logic [DW-1:0]         acc_data_q;
  logic [LINE_BYTES-1:0] acc_strb_q;
  logic                  out_valid_q;
  logic [ADDR-1:0]       out_addr_q;
  logic [DW-1:0]         out_data_q;
  logic [LINE_BYTES-1:0] out_strb_q;
  logic [CNT_W-1:0]      cnt_q;

  logic [NW-1:0]         n;
  logic [SW-1:0]         sum;
  logic                  complete;
  logic                  room;
  logic                  ready;
  logic                  fire;
  logic                  nonempty;
  logic [DW-1:0]         cur_d;
  logic [LINE_BYTES-1:0] cur_s;
  logic [DW-1:0]         spl_d;
  logic [LINE_BYTES-1:0] spl_s;

  // Beat size clamp, fill arithmetic and acceptance.
  always_comb begin
    n = (bus.in_bytes > NW'(IN_BYTES)) ? NW'(IN_BYTES) : bus.in_bytes;
    sum = {1'b0, fill_q} + SW'(n);
    complete = sum[LW];
    room = ({1'b0, fill_q} + SW'(IN_BYTES)) < SW'(LINE_BYTES);
    ready = (state_q == FILL) & (~out_valid_q | room);
    fire = bus.in_valid & ready;
    nonempty = complete ? |spl_s : |cur_s;
  end

  // Scatter beat bytes into the current line and the spill line.
  always_comb begin
    logic [SW-1:0] pos;
    int idx;
    cur_d = acc_data_q;
    cur_s = acc_strb_q;
    spl_d = '0;
    spl_s = '0;
    pos = '0;
    idx = 0;
    for (int k = 0; k < IN_BYTES; k++) begin
      pos = {1'b0, fill_q} + SW'(k);
      idx = int'(pos[LW-1:0]);
      if (NW'(k) < n) begin
        if (!pos[LW]) begin
          cur_d[idx*8 +: 8] = bus.in_data[k*8 +: 8];
          cur_s[idx] = 1'b1;
        end else begin
          spl_d[idx*8 +: 8] = bus.in_data[k*8 +: 8];
          spl_s[idx] = 1'b1;
        end
      end
    end
  end

  // Job FSM, accumulator and output line register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      fill_q      <= '0;
      line_addr_q <= '0;
      acc_data_q  <= '0;
      acc_strb_q  <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_strb_q  <= '0;
      cnt_q       <= '0;
    end else begin
      if (out_valid_q && bus.out_done) begin
        out_valid_q <= 1'b0;
        out_strb_q  <= '0;
        cnt_q       <= cnt_q + CNT_W'(1);
      end
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= FILL;
            fill_q      <= base_addr[LW-1:0];
            line_addr_q <= {base_addr[ADDR-1:LW], {LW{1'b0}}};
            acc_data_q  <= '0;
            acc_strb_q  <= '0;
            cnt_q       <= '0;
          end
        end
        FILL: begin
          if (fire) begin
            fill_q <= sum[LW-1:0];
            if (complete) begin
              out_valid_q <= 1'b1;
              out_addr_q  <= line_addr_q;
              out_data_q  <= cur_d;
              out_strb_q  <= cur_s;
              line_addr_q <= line_addr_q + ADDR'(LINE_BYTES);
              acc_data_q  <= spl_d;
              acc_strb_q  <= spl_s;
            end else begin
              acc_data_q  <= cur_d;
              acc_strb_q  <= cur_s;
            end
            if (bus.in_last) begin
              state_q <= nonempty ? FLUSH : DRAIN;
            end
          end
        end
        FLUSH: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_addr_q  <= line_addr_q;
            out_data_q  <= acc_data_q;
            out_strb_q  <= acc_strb_q;
            acc_data_q  <= '0;
            acc_strb_q  <= '0;
            state_q     <= DRAIN;
          end
        end
        DRAIN: begin
          if (!out_valid_q || bus.out_done) begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_strb  = out_strb_q;
  assign busy          = (state_q != IDLE);
  assign lines_emitted = cnt_q;
endmodule

// File: tb/tb_fetch_line_packer.sv
// Randomised bench for fetch_line_packer against a byte-address
// reference model, plus directed boundary scenarios.
module tb_fetch_line_packer;
  localparam int LB = 64;
  localparam int IB = 16;
  localparam int AW = 32;
  localparam int CW = 16;
  localparam int NW = $clog2(IB + 1);

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          busy;
  logic [CW-1:0] lines_emitted;

  fetch_line_packer_if #(
    .LINE_BYTES(LB), .IN_BYTES(IB), .ADDR(AW)
  ) bus ();

  fetch_line_packer #(
    .LINE_BYTES(LB), .IN_BYTES(IB), .ADDR(AW), .CNT_W(CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .base_addr(base_addr),
    .bus(bus),
    .busy(busy),
    .lines_emitted(lines_emitted)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [511:0] got,
                       input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] mask(input logic [511:0] d,
                                        input logic [63:0] s);
    logic [511:0] r;
    r = '0;
    for (int j = 0; j < LB; j++)
      if (s[j]) r[j*8 +: 8] = d[j*8 +: 8];
    return r;
  endfunction

  // reference model: bytes land at consecutive addresses from base
  logic [AW-1:0] m_base;
  logic [7:0]    m_bytes[$];

  logic [AW-1:0]  g_addr[$];
  logic [511:0]   g_data[$];
  logic [63:0]    g_strb[$];

  bit hold = 1'b1;
  int acc_pct = 100;

  logic           prev_v = 1'b0;
  logic           prev_ack = 1'b0;
  logic [AW-1:0]  p_addr;
  logic [511:0]   p_data;
  logic [63:0]    p_strb;

  // consumer: random acknowledge, records each acked line once
  always @(negedge clock) begin
    if (bus.out_valid === 1'b1 && reset === 1'b0) begin
      if (prev_v && !prev_ack) begin
        check("stable_addr", bus.out_addr, p_addr);
        check("stable_data", bus.out_data, p_data);
        check("stable_strb", bus.out_strb, p_strb);
      end
      p_addr = bus.out_addr;
      p_data = bus.out_data;
      p_strb = bus.out_strb;
      if (!hold && $urandom_range(1, 100) <= acc_pct) begin
        g_addr.push_back(bus.out_addr);
        g_data.push_back(bus.out_data);
        g_strb.push_back(bus.out_strb);
        bus.out_done = 1'b1;
        prev_ack = 1'b1;
      end else begin
        bus.out_done = 1'b0;
        prev_ack = 1'b0;
      end
      prev_v = 1'b1;
    end else begin
      bus.out_done = 1'b0;
      prev_v = 1'b0;
      prev_ack = 1'b0;
    end
  end

  task automatic pulse_start(input logic [AW-1:0] b);
    @(negedge clock);
    start = 1'b1;
    base_addr = b;
    @(negedge clock);
    start = 1'b0;
    base_addr = $urandom;
  endtask

  task automatic begin_job(input logic [AW-1:0] b);
    m_base = b;
    m_bytes.delete();
    g_addr.delete();
    g_data.delete();
    g_strb.delete();
    pulse_start(b);
    check("busy_after_start", busy, 1);
  endtask

  task automatic send_beat(input logic [127:0] d,
                           input int nb, input bit last);
    int waitc;
    int n;
    waitc = 0;
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.in_data = d;
    bus.in_bytes = NW'(nb);
    bus.in_last = last;
    #1;
    while (bus.in_ready !== 1'b1 && waitc < 300) begin
      @(negedge clock);
      #1;
      waitc++;
    end
    if (waitc >= 300) begin
      check("beat_accept_timeout", 0, 1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    n = (nb > IB) ? IB : nb;
    for (int k = 0; k < n; k++) m_bytes.push_back(d[k*8 +: 8]);
  endtask

  task automatic rand_beat(input bit last);
    logic [127:0] d;
    int nb;
    d = {$urandom, $urandom, $urandom, $urandom};
    nb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : IB;
    repeat ($urandom_range(0, 1)) @(negedge clock);
    send_beat(d, nb, last);
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (busy !== 1'b0 && c < 1000) begin
      @(negedge clock);
      c++;
    end
    check("job_idle", busy, 0);
  endtask

  task automatic finish_job(input string tag);
    logic [AW-1:0]  ea[$];
    logic [511:0]   ed[$];
    logic [63:0]    es[$];
    logic [AW-1:0]  ca, a, la;
    logic [511:0]   cd;
    logic [63:0]    cs;
    bit             have;
    int             off, nmin;
    wait_idle();
    have = 1'b0;
    ca = '0;
    cd = '0;
    cs = '0;
    for (int i = 0; i < m_bytes.size(); i++) begin
      a = m_base + AW'(i);
      la = a & ~AW'(LB - 1);
      off = int'(a[5:0]);
      if (!have || la != ca) begin
        if (have) begin
          ea.push_back(ca);
          ed.push_back(cd);
          es.push_back(cs);
        end
        have = 1'b1;
        ca = la;
        cd = '0;
        cs = '0;
      end
      cd[off*8 +: 8] = m_bytes[i];
      cs[off] = 1'b1;
    end
    if (have) begin
      ea.push_back(ca);
      ed.push_back(cd);
      es.push_back(cs);
    end
    check({tag, "_nlines"}, g_addr.size(), ea.size());
    check({tag, "_lines_emitted"}, lines_emitted, ea.size());
    nmin = (g_addr.size() < ea.size()) ? g_addr.size() : ea.size();
    for (int i = 0; i < nmin; i++) begin
      check({tag, "_addr"}, g_addr[i], ea[i]);
      check({tag, "_strb"}, g_strb[i], es[i]);
      check({tag, "_data"}, mask(g_data[i], g_strb[i]),
            mask(ed[i], es[i]));
    end
  endtask

  function automatic logic [63:0] got_strb(input int i);
    return (g_strb.size() > i) ? g_strb[i] : 64'hx;
  endfunction

  function automatic logic [AW-1:0] got_addr(input int i);
    return (g_addr.size() > i) ? g_addr[i] : 32'hx;
  endfunction

  initial begin
    logic [127:0] d;
    logic [511:0] ramp;
    int nbeats;

    reset = 1'b1;
    start = 1'b0;
    base_addr = '0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_bytes = '0;
    bus.in_last = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_addr", bus.out_addr, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_strb", bus.out_strb, 0);
    check("rst_busy", busy, 0);
    check("rst_lines", lines_emitted, 0);

    // aligned full line, prompt acknowledge
    hold = 1'b0;
    acc_pct = 100;
    begin_job(32'h1000);
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < IB; k++) d[k*8 +: 8] = 8'(b * IB + k);
      send_beat(d, IB, b == 3);
    end
    check("t1_latency", bus.out_valid, 1);
    finish_job("t1");
    for (int j = 0; j < LB; j++) ramp[j*8 +: 8] = 8'(j);
    check("t1_addr", got_addr(0), 32'h1000);
    check("t1_strb", got_strb(0), 64'hFFFF_FFFF_FFFF_FFFF);
    check("t1_data", (g_data.size() > 0) ? g_data[0] : 512'h0, ramp);

    // unaligned base, 12-byte beats, partial flush
    acc_pct = 70;
    begin_job(32'h1010);
    for (int b = 0; b < 5; b++) begin
      send_beat({$urandom, $urandom, $urandom, $urandom}, 12, b == 4);
      if (b == 0) pulse_start(32'hDEAD_0040);
    end
    finish_job("t2");
    check("t2_addr0", got_addr(0), 32'h1000);
    check("t2_strb0", got_strb(0), 64'hFFFF_FFFF_FFFF_0000);
    check("t2_addr1", got_addr(1), 32'h1040);
    check("t2_strb1", got_strb(1), 64'h0000_0000_0000_0FFF);

    // backpressure: acknowledge withheld
    hold = 1'b1;
    begin_job(32'h1000);
    for (int b = 0; b < 7; b++)
      send_beat({$urandom, $urandom, $urandom, $urandom}, IB, 1'b0);
    repeat (2) @(negedge clock);
    #1;
    check("t3_ready_low", bus.in_ready, 0);
    check("t3_out_valid", bus.out_valid, 1);
    check("t3_lines_held", lines_emitted, 0);
    hold = 1'b0;
    send_beat({$urandom, $urandom, $urandom, $urandom}, IB, 1'b1);
    finish_job("t3");

    // zero-byte beats and oversize clamp
    acc_pct = 60;
    begin_job(32'h2004);
    send_beat({$urandom, $urandom, $urandom, $urandom}, 16, 1'b0);
    send_beat({$urandom, $urandom, $urandom, $urandom}, 0, 1'b0);
    send_beat({$urandom, $urandom, $urandom, $urandom}, 20, 1'b0);
    send_beat({$urandom, $urandom, $urandom, $urandom}, 0, 1'b0);
    send_beat({$urandom, $urandom, $urandom, $urandom}, 9, 1'b0);
    send_beat({$urandom, $urandom, $urandom, $urandom}, 31, 1'b1);
    finish_job("t4");

    // single beat straddling a line boundary
    acc_pct = 100;
    begin_job(32'h1038);
    send_beat({$urandom, $urandom, $urandom, $urandom}, IB, 1'b1);
    finish_job("t5");
    check("t5_strb0", got_strb(0), 64'hFF00_0000_0000_0000);
    check("t5_strb1", got_strb(1), 64'h0000_0000_0000_00FF);
    check("t5_addr1", got_addr(1), 32'h1040);

    // reset mid-job with a line pending
    hold = 1'b1;
    begin_job(32'h3000);
    for (int b = 0; b < 4; b++)
      send_beat({$urandom, $urandom, $urandom, $urandom}, IB, 1'b0);
    check("t6_pending", bus.out_valid, 1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("t6_out_valid", bus.out_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_in_ready", bus.in_ready, 0);
    check("t6_lines", lines_emitted, 0);
    reset = 1'b0;
    hold = 1'b0;
    begin_job(32'h3008);
    for (int b = 0; b < 6; b++) rand_beat(b == 5);
    finish_job("t6_after");

    // random jobs
    for (int j = 0; j < 25; j++) begin
      acc_pct = $urandom_range(30, 100);
      begin_job($urandom & 32'h0000_FFFF);
      nbeats = $urandom_range(1, 12);
      for (int b = 0; b < nbeats; b++) begin
        rand_beat(b == nbeats - 1);
        if (b == 0 && nbeats > 1 && $urandom_range(0, 2) == 0)
          pulse_start($urandom);
      end
      finish_job("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_line_packer.md
Name: fetch_line_packer

Overview:
- Parametrised successor to the single-shot column packer stage of the fetch path.
- Sits between the column extractor output and the write-back port (ad_valid/ad_addr/ad_data/ad_done style).
- Accumulates variable-width filtered column beats into full output lines.
- Supports unaligned destination base, byte strobes, partial-line flush on last beat, and backpressure from the write-back consumer.

Parameters:
- LINE_BYTES, 64, output line size in bytes; power of two, at least 2*IN_BYTES.
- IN_BYTES, 16, maximum valid bytes per input beat.
- ADDR, 32, destination address width.
- CNT_W, 16, width of the lines_emitted counter.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a packing job; ignored when busy=1
- base_addr  in  ADDR  destination byte address, sampled on accepted start; may be unaligned
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_data  in  IN_BYTES*8  column bytes; byte k = in_data[8k+:8], packed from byte 0 upward
- in_bytes  in  $clog2(IN_BYTES+1)  count of valid bytes in the beat
- in_last  in  1  final beat of the job
- out_valid  out  1  line available
- out_addr  out  ADDR  LINE_BYTES-aligned line address
- out_data  out  LINE_BYTES*8  line data; byte j = out_data[8j+:8]
- out_strb  out  LINE_BYTES  per-byte write enable
- out_done  in  1  one-cycle consumer acknowledge of the current line
- busy  out  1  job in progress
- lines_emitted  out  CNT_W  count of lines acknowledged in the current job

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_addr=0, out_data=0, out_strb=0, busy=0, lines_emitted=0, state=IDLE, accumulator cleared.
- States: IDLE, FILL, FLUSH, DRAIN.
- IDLE:
  - start → FILL.
  - fill = base_addr mod LINE_BYTES; line_addr = base_addr aligned down.
  - Accumulator strobes cleared; lines_emitted=0.
- FILL:
  - Accepted beat writes bytes 0..n-1 into accumulator positions fill..fill+n-1, with n = min(in_bytes, IN_BYTES). in_bytes > IN_BYTES is clamped; in_bytes = 0 is a no-op.
  - If fill+n >= LINE_BYTES: line completes. Accumulator moves to the output register; out_valid=1 the next cycle; line_addr += LINE_BYTES.
  - Overflow bytes (fill+n-LINE_BYTES) spill to positions 0.. of the fresh accumulator.
  - On an unaligned base, the first line's strobe excludes leading bytes below the start offset.
- in_ready = (state==FILL) & (~out_valid | fill+IN_BYTES < LINE_BYTES). A completing beat is therefore never accepted while the output register is occupied.
- in_last accepted:
  - Accumulator non-empty after the beat → FLUSH. Emit a partial line with strobes only on filled bytes, as soon as the output register is free.
  - Accumulator empty (exact boundary) → DRAIN.
  - Completion and spill on the last beat: FLUSH emits the spill line after the completed line is acknowledged.
- out_done:
  - Honoured only when out_valid=1. Clears out_valid and out_strb in the same edge and increments lines_emitted.
  - Ignored when out_valid=0.
  - out_done coincident with a completing beat (out_valid was 0 that cycle) is impossible by the in_ready rule.
- DRAIN → IDLE when no line is pending after out_done; busy falls in the same edge.
- busy = (state != IDLE).
- out_addr, out_data and out_strb are stable while out_valid=1.
- Latency: completing beat accepted in cycle t → out_valid=1 at t+1.
- Throughput: one beat per cycle while the output register is free.
- reset mid-job: all state discarded, outputs return to reset values next edge, no line emitted.
- start while busy: ignored; base_addr not resampled.

Test Plan:
1. LINE_BYTES=64, IN_BYTES=16, base 0x1000, 4 beats × 16 bytes (0x00..0x3F), last on beat 4, out_done 1 cycle after out_valid → one line: addr 0x1000, strb all-ones, data byte j = j, lines_emitted=1, busy low after done.
2. base 0x1010, 5 beats × 12 bytes, last on beat 5:
   - Line 1 after beat 4: addr 0x1000, strb[15:0]=0, strb[63:16]=1.
   - Line 2: addr 0x1040, strb[11:0]=1, rest 0.
3. base 0x1000, 16-byte beats, out_done held low → after line 1, in_ready=1 for 3 more beats, then low at fill=48. No byte lost or duplicated after release; line 2 correct.
4. in_bytes=0 beats interleaved, plus in_bytes=20 (clamped to 16) → packing identical to a stream without the zero beats and with a 16-byte beat.
5. base 0x1038, one 16-byte beat with last → two lines:
   - 0x1000, strb[63:56].
   - 0x1040, strb[7:0].
   - lines_emitted=2.
6. reset asserted mid-FILL with out_valid=1 → next cycle out_valid=0, busy=0, in_ready=0. A new start works normally. A start pulse while busy is ignored.
